// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, reads the combinational instruction memory and registers one instruction per cycle for decode.
// Define FETCH_PERF_CNT_EN to build the saturating perf_fetched / perf_stalls counters; otherwise both ports read 0.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter logic [3:0]           HALT_OPCODE = 4'b1111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic                halted,
    output logic                pc_wrap,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_stalls
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PERF_W = 16;
    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        HALT_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 if_valid_d;
    logic [INSTR_W-1:0]   if_instr_d;
    logic [ADDR_W-1:0]    if_pc_d;
    logic                 halted_d;
    logic                 pc_wrap_d;
    logic                 is_halt_c;

    // The memory is combinational, so the PC register is the read address.
    assign imem_addr = pc_q;
    assign is_halt_c = (imem_instr[INSTR_W-1 -: OP_W] == HALT_OPCODE);

    // State, PC and decode-side output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            halted   <= 1'b0;
            pc_wrap  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_valid <= if_valid_d;
            if_instr <= if_instr_d;
            if_pc    <= if_pc_d;
            halted   <= halted_d;
            pc_wrap  <= pc_wrap_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a rule below changes it
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid;
        if_instr_d = if_instr;
        if_pc_d    = if_pc;
        halted_d   = halted;
        pc_wrap_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (fetch_en) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    // Flush overrides a stall: the held instruction is on the wrong path.
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (stall && if_valid) begin
                    if_valid_d = if_valid;
                end else if (!fetch_en) begin
                    if_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    if_instr_d = imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (is_halt_c) begin
                        // PC parks on the HALT so imem_addr keeps pointing at it.
                        state_d = HALT_WAIT;
                    end else begin
                        pc_d      = pc_q + ADDR_W'(1);
                        pc_wrap_d = (pc_q == PC_MAX);
                    end
                end
            end

            HALT_WAIT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = HALTED;
                end
            end

            HALTED: begin
                if_valid_d = 1'b0;
                halted_d   = 1'b1;
                if (redirect_valid) begin
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                end
            end

            default: begin
                if_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] fetched_q;
    logic [PERF_W-1:0] stalls_q;

    // Saturating counters: accepted deliveries and back-pressured cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (if_valid && !stall && (fetched_q != '1)) begin
                fetched_q <= fetched_q + PERF_W'(1);
            end
            if (if_valid && stall && (stalls_q != '1)) begin
                stalls_q <= stalls_q + PERF_W'(1);
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side initiator for the 256x16 combinational instruction memory. It owns the PC, drives the memory read address, and registers each returned instruction for decode. Downstream handshake is valid/stall. Supports branch redirect and stops fetching when it sees a HALT opcode.

Parameters:
ADDR_W, 8, PC and instruction-memory address width
INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1 -: 4]
RESET_PC, 0, PC value after reset
HALT_OPCODE, 4'b1111, opcode that stops fetching

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
fetch_en  input  1  permit fetching; low = no new fetch
stall  input  1  downstream not ready; hold all if_* outputs and PC
redirect_valid  input  1  one-cycle branch/jump request
redirect_pc  input  ADDR_W  target PC for redirect
imem_addr  output  ADDR_W  read address to instruction memory, equals PC (combinational)
imem_instr  input  INSTR_W  instruction returned combinationally for imem_addr
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  INSTR_W  registered instruction
if_pc  output  ADDR_W  address the instruction was fetched from
halted  output  1  HALT delivered and accepted; fetch stopped
pc_wrap  output  1  one-cycle pulse when PC wraps from 2^ADDR_W-1 to 0
perf_fetched  output  16  instructions delivered (see Optional Feature)
perf_stalls  output  16  stall cycles with if_valid=1 (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, halted=0, pc_wrap=0, perf counters=0. Reset wins over all other inputs, including mid-stall and while HALTED.
- States:
  - IDLE: if_valid=0. Go to FETCH when fetch_en=1.
  - FETCH: normal fetching (rules below).
  - HALT_WAIT: the HALT instruction is on if_*.
  - HALTED: no fetching.
- "Advance" in FETCH means: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1 (modulo 2^ADDR_W).
- FETCH priority, highest first, evaluated each cycle:
  1. redirect_valid: pc<=redirect_pc, if_valid<=0 (flushes the held instruction even if stall=1), no fetch this cycle.
  2. stall=1 and if_valid=1: hold pc and all if_*.
  3. fetch_en=0: if_valid<=0 when not stalled; go to IDLE, pc held.
  4. Otherwise advance. Latency: address to if_valid is 1 cycle; throughput 1 instruction/cycle.
- If the advanced instruction's opcode == HALT_OPCODE: present it normally (if_valid=1), do not increment pc, go to HALT_WAIT.
- HALT_WAIT:
  - stall=1: hold outputs.
  - stall=0: the HALT is accepted; next cycle if_valid=0, halted=1, state HALTED.
  - redirect_valid in HALT_WAIT behaves as in FETCH: flush, return to FETCH, halted stays 0.
- HALTED:
  - imem_addr holds the HALT address; if_valid=0; halted=1.
  - Only rst or redirect_valid exits. Redirect sets pc<=redirect_pc, halted<=0, state FETCH.
- pc_wrap: 1-cycle pulse on the cycle pc updates from 255 to 0 by increment. Redirects never pulse it.
- stall while if_valid=0 has no effect; the unit keeps fetching.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: perf_fetched increments once per instruction accepted downstream (if_valid=1 and stall=0), including HALT. perf_stalls increments each cycle with if_valid=1 and stall=1. Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- IMEM[0..5]=4205,440A,0650,1E88,5614,F000 (hex); rst then fetch_en=1, stall=0 -> if_instr 4205..F000 on consecutive cycles with if_pc 0..5; if_valid low the cycle after F000; halted=1; imem_addr stays 5.
- Same program, stall=1 for 3 cycles while if_instr=0650 -> if_instr/if_pc (0650/2) and imem_addr=3 held; resumes with 1E88; perf_stalls=3 with FETCH_PERF_CNT_EN.
- redirect_valid=1, redirect_pc=4 while if_instr=440A and stall=1 -> next cycle if_valid=0; following cycle if_instr=5614, if_pc=4.
- In HALTED, redirect_pc=0 -> halted clears, program replays from 4205; perf_fetched counts 6 then continues from 6.
- IMEM[255]=0650, redirect to 255 -> if_pc=255, pc_wrap pulses once, next if_pc=0.
- rst asserted while in HALT_WAIT with stall=1 -> next cycle if_valid=0, halted=0, imem_addr=0, state IDLE until fetch_en.
